// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// instruction field codes, datapath select constants and decode helpers.
package arm_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] op;
    logic       i;
    logic [3:0] cmd;
    logic       s;
    logic       u;
    logic       l;
    logic [3:0] rd;
  } dec_t;

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR) || (cmd == CMD_MOV);
  endfunction

  // Only the arithmetic ops produce meaningful carry/overflow.
  function automatic logic cmd_is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [2:0] alu_of_cmd(input logic [3:0] cmd);
    logic [2:0] alu;
    case (cmd)
      CMD_ADD: alu = ALU_ADD;
      CMD_SUB: alu = ALU_SUB;
      CMD_CMP: alu = ALU_SUB;
      CMD_AND: alu = ALU_AND;
      CMD_ORR: alu = ALU_ORR;
      CMD_MOV: alu = ALU_MOV;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  function automatic logic [1:0] imm_of_op(input logic [1:0] op);
    logic [1:0] imm;
    case (op)
      OP_MEM:  imm = IMM_MEM;
      OP_BR:   imm = IMM_BR;
      default: imm = IMM_DP;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational ARM condition-code evaluation against the NZCV register.
// cond = 1111 (NV) always evaluates as not executed.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign w_n  = i_flags[3];
  assign w_z  = i_flags[2];
  assign w_c  = i_flags[1];
  assign w_v  = i_flags[0];
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset sequencing FSM: decodes the latched instruction and
// drives all datapath selects/enables. Optional MEM_WAIT_EN adds mem_ready stalls.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4
// DECODE | read registers, evaluate condition, dispatch
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded word to Rd
// MEMWR  | write store data to memory
// EXECR  | ALU op with register operand
// EXECI  | ALU op with immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <= PC+8+imm24
module multicycle_controller
  import arm_ctrl_pkg::*;
#(
  parameter int INSTR_W   = 32,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_W-1:0]   inst,
  input  logic [3:0]           ALUFlags,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           flags,
  output logic [3:0]           state
);

  logic [3:0] r_state;
  logic [3:0] r_flags;
  logic [3:0] w_next;
  dec_t       w_dec;
  logic       w_cond_ex;
  logic       w_supported;
  logic       w_mem_go;
  logic       w_flag_load;
  logic       w_rd_pc;
  logic [2:0] w_alu;
  logic       w_unused;

  assign w_dec.cond = inst[31:28];
  assign w_dec.op   = inst[27:26];
  assign w_dec.i    = inst[25];
  assign w_dec.cmd  = inst[24:21];
  assign w_dec.s    = inst[20];
  assign w_dec.u    = inst[23];
  assign w_dec.l    = inst[20];
  assign w_dec.rd   = inst[15:12];

  // Register/immediate operand fields are consumed by the datapath, not here.
  assign w_unused = ^{inst[19:16], inst[11:0], mem_ready};

`ifdef MEM_WAIT_EN
  assign w_mem_go = mem_ready;
`else
  assign w_mem_go = 1'b1;
`endif

  cond_check u_cond_check (
    .i_cond    (w_dec.cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_supported = (w_dec.op == OP_MEM) || (w_dec.op == OP_BR) ||
                       ((w_dec.op == OP_DP) && cmd_supported(w_dec.cmd));

  assign w_rd_pc = (w_dec.rd == 4'hF);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!w_cond_ex || !w_supported) begin
          w_next = S_FETCH;
        end else begin
          case (w_dec.op)
            OP_MEM:  w_next = S_MEMADR;
            OP_BR:   w_next = S_BRANCH;
            OP_DP:   w_next = w_dec.i ? S_EXECI : S_EXECR;
            default: w_next = S_FETCH;
          endcase
        end
      end
      S_MEMADR: w_next = w_dec.l ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mem_go ? S_FETCH : S_MEMWR;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  assign w_flag_load = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                       (w_dec.s || (w_dec.cmd == CMD_CMP));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_flag_load) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (cmd_is_arith(w_dec.cmd)) begin
          r_flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

  // Outputs are Moore-decoded from state and the latched instruction; reset forces all low.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ImmSrc    = IMM_DP;
    RegSrc    = 2'b00;
    w_alu     = ALU_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          IRWrite   = w_mem_go;
          PCWrite   = w_mem_go;
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
        end
        S_DECODE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ImmSrc  = imm_of_op(w_dec.op);
        end
        S_MEMADR: begin
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_MEM;
          w_alu   = w_dec.u ? ALU_ADD : ALU_SUB;
        end
        S_MEMRD: AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          PCWrite   = w_rd_pc;
        end
        S_MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          RegSrc   = 2'b10;
        end
        S_EXECR: begin
          ALUSrcB = SRCB_REG;
          w_alu   = alu_of_cmd(w_dec.cmd);
        end
        S_EXECI: begin
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_DP;
          w_alu   = alu_of_cmd(w_dec.cmd);
        end
        S_ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = (w_dec.cmd != CMD_CMP);
          PCWrite   = (w_dec.cmd != CMD_CMP) && w_rd_pc;
        end
        S_BRANCH: begin
          RegSrc    = 2'b01;
          ALUSrcB   = SRCB_IMM;
          ImmSrc    = IMM_BR;
          ResultSrc = RES_ALU;
          PCWrite   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUControl = ALUCTRL_W'(w_alu);
  assign flags      = r_flags;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller, plus hand-written
// sequences for latency and (when MEM_WAIT_EN is defined) memory-wait behaviour.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  flags, state;
  logic [16:0] act_ctrl;

  multicycle_controller #(.INSTR_W(32), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .inst(inst), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .flags(flags), .state(state)
  );

  assign act_ctrl = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4;
  localparam logic [3:0] MW = 4'd5, ER = 4'd6, EI = 4'd7, WB = 4'd8, BR = 4'd9;

  // {pcw irw mw rw adr srca}_srcb_res_imm_regsrc_alu
  localparam logic [16:0] K_ZERO    = 17'b000000_00_00_00_00_000;
  localparam logic [16:0] K_FETCH   = 17'b110001_10_10_00_00_000;
  localparam logic [16:0] K_DEC_DP  = 17'b000001_10_00_00_00_000;
  localparam logic [16:0] K_DEC_MEM = 17'b000001_10_00_01_00_000;
  localparam logic [16:0] K_DEC_BR  = 17'b000001_10_00_10_00_000;
  localparam logic [16:0] K_EI_ADD  = 17'b000000_01_00_00_00_000;
  localparam logic [16:0] K_ER_SUB  = 17'b000000_00_00_00_00_001;
  localparam logic [16:0] K_ER_AND  = 17'b000000_00_00_00_00_010;
  localparam logic [16:0] K_ER_MOV  = 17'b000000_00_00_00_00_100;
  localparam logic [16:0] K_WB_RW   = 17'b000100_00_00_00_00_000;
  localparam logic [16:0] K_WB_PC   = 17'b100100_00_00_00_00_000;
  localparam logic [16:0] K_MA_ADD  = 17'b000000_01_00_01_00_000;
  localparam logic [16:0] K_MA_SUB  = 17'b000000_01_00_01_00_001;
  localparam logic [16:0] K_MR      = 17'b000010_00_00_00_00_000;
  localparam logic [16:0] K_MWB     = 17'b000100_00_01_00_00_000;
  localparam logic [16:0] K_MWB_PC  = 17'b100100_00_01_00_00_000;
  localparam logic [16:0] K_MW      = 17'b001010_00_00_00_10_000;
  localparam logic [16:0] K_BR      = 17'b100000_01_10_10_01_000;

  localparam logic [31:0] I_ADDS  = 32'hE2921005;
  localparam logic [31:0] I_CMP   = 32'hE1510001;
  localparam logic [31:0] I_BEQ   = 32'h0A000002;
  localparam logic [31:0] I_BNE   = 32'h1A000002;
  localparam logic [31:0] I_ANDS  = 32'hE0111002;
  localparam logic [31:0] I_LDR   = 32'hE5910004;
  localparam logic [31:0] I_STR   = 32'hE5010004;
  localparam logic [31:0] I_LDRPC = 32'hE591F004;
  localparam logic [31:0] I_MOVPC = 32'hE1A0F003;
  localparam logic [31:0] I_OP11  = 32'hEC000000;
  localparam logic [31:0] I_EOR   = 32'hE0211002;
  localparam logic [31:0] I_NV    = 32'hF2921005;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic [3:0]  af;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  fl;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [31:0] i, input logic [3:0] a,
                     input logic [3:0] s, input logic [16:0] c, input logic [3:0] f);
    vec_t v;
    v.rst = r; v.ins = i; v.af = a; v.st = s; v.ctrl = c; v.fl = f;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    logic saw_rw;

    // reset + instruction stream, one row per cycle
    add(1, I_ADDS, 4'h0, F, K_ZERO, 4'h0);
    add(0, I_ADDS, 4'h0, F, K_FETCH, 4'h0);
    add(0, I_ADDS, 4'h0, D, K_DEC_DP, 4'h0);
    add(0, I_ADDS, 4'h0, EI, K_EI_ADD, 4'h0);
    add(0, I_ADDS, 4'h0, WB, K_WB_RW, 4'h0);
    add(0, I_CMP, 4'h6, F, K_FETCH, 4'h0);
    add(0, I_CMP, 4'h6, D, K_DEC_DP, 4'h0);
    add(0, I_CMP, 4'h6, ER, K_ER_SUB, 4'h0);
    add(0, I_CMP, 4'h6, WB, K_ZERO, 4'h6);
    add(0, I_BEQ, 4'h0, F, K_FETCH, 4'h6);
    add(0, I_BEQ, 4'h0, D, K_DEC_BR, 4'h6);
    add(0, I_BEQ, 4'h0, BR, K_BR, 4'h6);
    add(0, I_BNE, 4'h0, F, K_FETCH, 4'h6);
    add(0, I_BNE, 4'h0, D, K_DEC_BR, 4'h6);
    add(0, I_ANDS, 4'h9, F, K_FETCH, 4'h6);
    add(0, I_ANDS, 4'h9, D, K_DEC_DP, 4'h6);
    add(0, I_ANDS, 4'h9, ER, K_ER_AND, 4'h6);
    add(0, I_ANDS, 4'h9, WB, K_WB_RW, 4'hA);
    add(0, I_LDR, 4'h0, F, K_FETCH, 4'hA);
    add(0, I_LDR, 4'h0, D, K_DEC_MEM, 4'hA);
    add(0, I_LDR, 4'h0, MA, K_MA_ADD, 4'hA);
    add(0, I_LDR, 4'h0, MR, K_MR, 4'hA);
    add(0, I_LDR, 4'h0, MB, K_MWB, 4'hA);
    add(0, I_STR, 4'h0, F, K_FETCH, 4'hA);
    add(0, I_STR, 4'h0, D, K_DEC_MEM, 4'hA);
    add(0, I_STR, 4'h0, MA, K_MA_SUB, 4'hA);
    add(0, I_STR, 4'h0, MW, K_MW, 4'hA);
    add(0, I_LDRPC, 4'h0, F, K_FETCH, 4'hA);
    add(0, I_LDRPC, 4'h0, D, K_DEC_MEM, 4'hA);
    add(0, I_LDRPC, 4'h0, MA, K_MA_ADD, 4'hA);
    add(0, I_LDRPC, 4'h0, MR, K_MR, 4'hA);
    add(0, I_LDRPC, 4'h0, MB, K_MWB_PC, 4'hA);
    add(0, I_MOVPC, 4'hF, F, K_FETCH, 4'hA);
    add(0, I_MOVPC, 4'hF, D, K_DEC_DP, 4'hA);
    add(0, I_MOVPC, 4'hF, ER, K_ER_MOV, 4'hA);
    add(0, I_MOVPC, 4'hF, WB, K_WB_PC, 4'hA);
    add(0, I_OP11, 4'hF, F, K_FETCH, 4'hA);
    add(0, I_OP11, 4'hF, D, K_DEC_DP, 4'hA);
    add(0, I_EOR, 4'hF, F, K_FETCH, 4'hA);
    add(0, I_EOR, 4'hF, D, K_DEC_DP, 4'hA);
    add(0, I_NV, 4'hF, F, K_FETCH, 4'hA);
    add(0, I_NV, 4'hF, D, K_DEC_DP, 4'hA);
    // reset in the middle of EXECI: no flag load, back to FETCH
    add(0, I_ADDS, 4'hF, F, K_FETCH, 4'hA);
    add(0, I_ADDS, 4'hF, D, K_DEC_DP, 4'hA);
    add(1, I_ADDS, 4'hF, EI, K_ZERO, 4'hA);
    add(0, I_ADDS, 4'hF, F, K_FETCH, 4'h0);

    reset = 1'b1; inst = 32'h0; ALUFlags = 4'h0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      reset = tv[k].rst; inst = tv[k].ins; ALUFlags = tv[k].af;
      #1;
      chk($sformatf("row%0d state", k), {28'h0, state}, {28'h0, tv[k].st});
      chk($sformatf("row%0d ctrl", k), {15'h0, act_ctrl}, {15'h0, tv[k].ctrl});
      chk($sformatf("row%0d flags", k), {28'h0, flags}, {28'h0, tv[k].fl});
    end

    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;

`ifdef MEM_WAIT_EN
    inst = I_STR; mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("wait%0d state", k), {28'h0, state}, {28'h0, F});
      chk($sformatf("wait%0d pcwrite", k), {31'h0, PCWrite}, 32'h0);
      chk($sformatf("wait%0d irwrite", k), {31'h0, IRWrite}, 32'h0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1 chk("wait fetch go pcwrite", {31'h0, PCWrite}, 32'h1);
    @(negedge clk); #1 chk("wait decode", {28'h0, state}, {28'h0, D});
    @(negedge clk); mem_ready = 1'b0;
    #1 chk("wait memadr", {28'h0, state}, {28'h0, MA});
    @(negedge clk); #1 chk("wait memwr", {28'h0, state}, {28'h0, MW});
    chk("wait memwr mw", {31'h0, MemWrite}, 32'h1);
    @(negedge clk); #1 chk("wait memwr hold", {28'h0, state}, {28'h0, MW});
    chk("wait memwr hold mw", {31'h0, MemWrite}, 32'h1);
    reset = 1'b1;
    #1 chk("wait reset mw", {31'h0, MemWrite}, 32'h0);
    @(negedge clk); #1 chk("wait reset state", {28'h0, state}, {28'h0, F});
    reset = 1'b0; mem_ready = 1'b1;
`else
    // mem_ready is ignored: LDR still completes in 5 cycles with it held low
    inst = I_LDR; mem_ready = 1'b0;
    #1 chk("lat start", {28'h0, state}, {28'h0, F});
    n = 1; saw_rw = 1'b0;
    while (n <= 20) begin
      @(negedge clk); #1;
      if (state == F) break;
      if (RegWrite) saw_rw = 1'b1;
      n++;
    end
    chk("ldr latency", n, 5);
    chk("ldr regwrite", {31'h0, saw_rw}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
